// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-level handshake bundle between NUM_REQ message
// sources, the round-robin arbiter and the UART TX serializer.
// slave modport is the arbiter's view; master is the surrounding system.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_evt;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, busy, timeout_evt
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, busy, timeout_evt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART byte transmitter
// between NUM_REQ sources. A grant is held for a whole message (until the
// byte flagged last is accepted), then priority rotates past the owner.
// Optional stall timeout: define UART_ARB_TIMEOUT_EN to enable forced
// release after TIMEOUT_CYCLES cycles of the owner presenting no byte.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 26040
) (
    input logic               clk_25mhz,
    input logic               reset_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic [PW-1:0]      owner_idx;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;

    logic [PW-1:0]      scan_idx;
    logic [PW-1:0]      sel_idx;
    logic               sel_found;
    logic               handshake;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0]      stall_q, stall_d;
    logic               timeout_fire;
`endif

    // Decode the current owner's index and its byte-lane signals from the one-hot grant.
    always_comb begin
        owner_idx   = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx   = PW'(i);
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first valid requester scanning upward from ptr+1, wrapping.
    always_comb begin
        scan_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PW'((32'(ptr_q) + k) % NUM_REQ);
            if (!sel_found && bus.req_valid[scan_idx]) begin
                sel_idx   = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    assign handshake = owner_valid & bus.tx_ready;

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == OWNED);
    assign bus.tx_valid  = owner_valid;
    assign bus.tx_data   = owner_valid ? owner_data : 8'h00;
    assign bus.req_ready = grant_q & bus.req_valid & {NUM_REQ{bus.tx_ready}};

    // Next-state logic: grant on request in IDLE, release on last-byte handshake (or stall timeout).
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d      = stall_q;
        timeout_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = OWNED;
                    grant_d = NUM_REQ'(1) << sel_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            OWNED: begin
                if (handshake && owner_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (handshake) begin
                    stall_d = '0;
                end else if (!owner_valid) begin
                    if (stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_fire = 1'b1;
                        state_d      = IDLE;
                        grant_d      = '0;
                        ptr_d        = owner_idx;
                    end else begin
                        stall_d = stall_q + CW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_evt = timeout_fire;
`else
    assign bus.timeout_evt = 1'b0;
`endif

    // State, grant and priority pointer registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter for the owner's idle cycles.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a per-cycle
// reference model (owner index / pointer / stall count) plus literal checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 26040;

    logic clk_25mhz = 1'b0;
    logic reset_n   = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the transmitter, where priority points, stall cycles.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_stall = 0;

    always @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_stall = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && bus.req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_stall = 0;
                end
            end
        end else begin : owned_step
            int o;
            o = m_owner;
            if (bus.req_valid[o] && bus.tx_ready) begin
                if (bus.req_last[o]) begin
                    m_ptr   = o;
                    m_owner = -1;
                end else begin
                    m_stall = 0;
                end
            end else if (!bus.req_valid[o]) begin
`ifdef UART_ARB_TIMEOUT_EN
                if (m_stall == T - 1) begin
                    m_ptr   = o;
                    m_owner = -1;
                end else begin
                    m_stall = m_stall + 1;
                end
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    logic [N-1:0] e_grant, e_ready;
    logic         e_valid, e_evt;
    logic [7:0]   e_data;

    always @(negedge clk_25mhz) begin
        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_evt   = 1'b0;
        e_data  = 8'h00;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid = bus.req_valid[m_owner];
            if (e_valid) e_data = bus.req_data[8*m_owner +: 8];
            if (e_valid && bus.tx_ready) e_ready[m_owner] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            if (!e_valid && m_stall == T - 1) e_evt = 1'b1;
`endif
        end
        chk("cyc_grant",    32'(bus.grant),       32'(e_grant));
        chk("cyc_busy",     32'(bus.busy),        32'(m_owner >= 0));
        chk("cyc_tx_valid", 32'(bus.tx_valid),    32'(e_valid));
        chk("cyc_tx_data",  32'(bus.tx_data),     32'(e_data));
        chk("cyc_req_rdy",  32'(bus.req_ready),   32'(e_ready));
        chk("cyc_timeout",  32'(bus.timeout_evt), 32'(e_evt));
    end

    logic [7:0] msg[$];
    logic [7:0] seen[$];

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    // Drive msg from requester r, pulsing tx_ready every 'period' cycles; ends at posedge+1 after the final accept.
    task automatic send_msg(input int r, input int period, input logic [N-1:0] exp_gnt,
                            input bit last_on_end, input int budget);
        int idx = 0;
        int cyc = 0;
        seen.delete();
        while (idx < msg.size() && cyc < budget) begin
            bus.req_valid[r]        = 1'b1;
            bus.req_data[8*r +: 8]  = msg[idx];
            bus.req_last[r]         = last_on_end && (idx == msg.size() - 1);
            bus.tx_ready            = ((cyc + 1) % period == 0);
            @(negedge clk_25mhz);
            if (bus.req_ready[r]) begin
                seen.push_back(bus.tx_data);
                chk("msg_grant", 32'(bus.grant), 32'(exp_gnt));
                idx++;
            end
            tick();
            cyc++;
        end
        bus.req_valid[r] = 1'b0;
        bus.req_last[r]  = 1'b0;
        bus.tx_ready     = 1'b0;
        chk("msg_done", 32'(idx), 32'(msg.size()));
    endtask

    logic [N-1:0] fair_exp  [16] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8,
                                     4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
    logic [7:0]   fair_data [16] = '{8'h00, 8'h50, 8'h00, 8'h51, 8'h00, 8'h52, 8'h00, 8'h53,
                                     8'h00, 8'h50, 8'h00, 8'h51, 8'h00, 8'h52, 8'h00, 8'h53};

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_evt;
        int npulse;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        #5 reset_n = 1'b0;

        // Reset held with random inputs: everything stays quiet.
        repeat (6) begin
            tick();
            bus.req_valid = N'($urandom);
            bus.req_data  = 32'($urandom);
            bus.req_last  = N'($urandom);
            bus.tx_ready  = 1'($urandom);
            @(negedge clk_25mhz);
            chk("rst_grant",    32'(bus.grant),     32'h0);
            chk("rst_busy",     32'(bus.busy),      32'h0);
            chk("rst_tx_valid", 32'(bus.tx_valid),  32'h0);
            chk("rst_req_rdy",  32'(bus.req_ready), 32'h0);
        end
        tick();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        reset_n       = 1'b1;
        repeat (4) begin
            @(negedge clk_25mhz);
            chk("idle_grant",    32'(bus.grant),    32'h0);
            chk("idle_busy",     32'(bus.busy),     32'h0);
            chk("idle_tx_valid", 32'(bus.tx_valid), 32'h0);
        end
        tick();

        // Single three-byte message from requester 1 at UART byte pace.
        msg = '{8'h41, 8'h42, 8'h43};
        send_msg(1, 2604, 4'b0010, 1'b1, 20000);
        chk("msg1_grant_after", 32'(bus.grant), 32'h0);
        chk("msg1_busy_after",  32'(bus.busy),  32'h0);
        chk("msg1_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("msg1_byte0", 32'(seen[0]), 32'h41);
            chk("msg1_byte1", 32'(seen[1]), 32'h42);
            chk("msg1_byte2", 32'(seen[2]), 32'h43);
        end

        // Fairness: all four hold one-byte messages; rotation with one idle cycle between.
        reset_n = 1'b0;
        #5;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h53525150;
        bus.req_last  = 4'b1111;
        bus.tx_ready  = 1'b1;
        reset_n       = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_25mhz);
            chk("fair_grant", 32'(bus.grant), 32'(fair_exp[c]));
            chk("fair_data",  32'(bus.tx_data), 32'(fair_data[c]));
        end
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;

        // Backpressure: requester 2 granted, serializer not ready for 5000 cycles.
        bus.req_valid[2]       = 1'b1;
        bus.req_data[16 +: 8]  = 8'hA5;
        bus.req_last[2]        = 1'b1;
        @(negedge clk_25mhz);
        chk("bp_idle_grant", 32'(bus.grant), 32'h0);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk_25mhz);
            chk("bp_grant",   32'(bus.grant),     32'h4);
            chk("bp_data",    32'(bus.tx_data),   32'hA5);
            chk("bp_req_rdy", 32'(bus.req_ready), 32'h0);
        end
        tick();
        bus.tx_ready = 1'b1;
        @(negedge clk_25mhz);
        chk("bp_accept", 32'(bus.req_ready), 32'h4);
        tick();
        bus.tx_ready  = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Reset in the middle of a four-byte message from requester 3.
        msg = '{8'hC0, 8'hC1};
        send_msg(3, 1, 4'b1000, 1'b0, 100);
        bus.req_valid[3]      = 1'b1;
        bus.req_data[24 +: 8] = 8'hC2;
        @(negedge clk_25mhz);
        chk("mid_grant",  32'(bus.grant),   32'h8);
        chk("mid_data",   32'(bus.tx_data), 32'hC2);
        #5 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant",    32'(bus.grant),    32'h0);
        chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("mid_rst_busy",     32'(bus.busy),     32'h0);
        tick();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        reset_n       = 1'b1;
        @(negedge clk_25mhz);
        chk("mid_rel_idle",  32'(bus.grant), 32'h0);
        @(negedge clk_25mhz);
        chk("mid_rel_first", 32'(bus.grant), 32'h1);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Owner stalls mid-message: forced release only with the timeout feature.
        reset_n = 1'b0;
        #5 reset_n = 1'b1;
        tick();
        msg = '{8'hD0};
        send_msg(3, 1, 4'b1000, 1'b0, 100);
        first_evt = -1;
        npulse    = 0;
        for (int c = 1; c <= 30000; c++) begin
            @(negedge clk_25mhz);
            if (bus.timeout_evt) begin
                npulse++;
                if (first_evt < 0) first_evt = c;
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_cycle",  32'(first_evt), 32'(T));
        chk("to_pulses", 32'(npulse), 32'd1);
        chk("to_grant",  32'(bus.grant), 32'h0);
        tick();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        @(negedge clk_25mhz);
        @(negedge clk_25mhz);
        chk("to_next_first", 32'(bus.grant), 32'h1);
`else
        chk("hold_pulses", 32'(npulse), 32'd0);
        chk("hold_grant",  32'(bus.grant), 32'h8);
        chk("hold_busy",   32'(bus.busy),  32'h1);
`endif
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
